// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus-side controller: register map,
// STATUS/CTRL bit positions and the bus-cycle FSM encoding.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_OVERRUN  = 4;
    localparam int STAT_IRQ      = 7;

    localparam int CTRL_RX_IE  = 0;
    localparam int CTRL_TX_IE  = 1;
    localparam int CTRL_OV_IE  = 2;
    localparam int CTRL_TX_RST = 6;
    localparam int CTRL_RX_RST = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchroniser for asynchronous CPU bus inputs. Deliberately
// unreset so the chain keeps tracking the real bus level through a reset.
module bus_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_bus_ctrl.sv
// Decodes 6502-style bus cycles into the UART register map and drives
// the TX/RX FIFO strobes, sticky overrun flag and active-low interrupt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no bus cycle in progress, waiting for phi2 rise with ncs low
// S_READ  | CPU read in progress, data driven onto the bus
// S_WRITE | CPU write in progress, bus_din sampled every clk
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phi2,
    input  logic              ncs,
    input  logic              nwe,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] bus_din,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_write_trig,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic              tx_fifo_reset,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_read_active,
    input  logic              rx_full,
    input  logic              rx_empty,
    input  logic              rx_push,
    output logic              rx_fifo_reset,
    output logic              nirq
);

    logic [4:0] sync_d;
    logic [4:0] sync_q;
    logic       phi2_s;
    logic       ncs_s;
    logic       nwe_s;
    logic [1:0] addr_s;
    logic       phi2_prev;
    logic       phi2_rise;
    logic       phi2_fall;

    bus_state_t        state;
    bus_state_t        state_next;
    logic              commit;
    logic              read_exit;
    logic [1:0]        cyc_addr;
    logic              rd_empty_q;
    logic [DATA_W-1:0] wr_data;
    logic [2:0]        ctrl_q;
    logic              overrun;
    logic              irq_comb;
    logic [DATA_W-1:0] status_val;
    logic [DATA_W-1:0] read_mux;

    assign sync_d = {phi2, ncs, nwe, addr};

    bus_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (5)
    ) u_bus_sync (
        .clk (clk),
        .d   (sync_d),
        .q   (sync_q)
    );

    assign {phi2_s, ncs_s, nwe_s, addr_s} = sync_q;

    // Reset to 1 so a phi2 already high at reset release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) phi2_prev <= 1'b1;
        else       phi2_prev <= phi2_s;
    end

    assign phi2_rise = phi2_s & ~phi2_prev;
    assign phi2_fall = ~phi2_s & phi2_prev;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (phi2_rise && !ncs_s) state_next = nwe_s ? S_READ : S_WRITE;
            end
            S_READ: begin
                if (ncs_s || phi2_fall) state_next = S_IDLE;
            end
            S_WRITE: begin
                if (ncs_s) begin
                    state_next = S_IDLE;
                end else if (phi2_fall) begin
                    state_next = S_IDLE;
                    commit     = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign read_exit = (state == S_READ) && (state_next != S_READ);

    assign irq_comb = (ctrl_q[CTRL_RX_IE] & ~rx_empty) |
                      (ctrl_q[CTRL_TX_IE] & tx_empty)  |
                      (ctrl_q[CTRL_OV_IE] & overrun);

    always_comb begin
        status_val                = '0;
        status_val[STAT_TX_EMPTY] = tx_empty;
        status_val[STAT_TX_FULL]  = tx_full;
        status_val[STAT_RX_EMPTY] = rx_empty;
        status_val[STAT_RX_FULL]  = rx_full;
        status_val[STAT_OVERRUN]  = overrun;
        status_val[STAT_IRQ]      = irq_comb;
    end

    always_comb begin
        read_mux = '0;
        case (cyc_addr)
            REG_DATA:   read_mux = rd_empty_q ? '0 : rx_data;
            REG_STATUS: read_mux = status_val;
            REG_CTRL:   read_mux = {{(DATA_W-3){1'b0}}, ctrl_q};
            default:    read_mux = '0;
        endcase
    end

    // The pop decision is frozen at READ entry so a FIFO that fills mid-cycle
    // cannot produce a late second pop.
    assign rx_read_active = (state == S_READ) && (cyc_addr == REG_DATA) && !rd_empty_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_addr      <= '0;
            rd_empty_q    <= 1'b1;
            wr_data       <= '0;
            tx_data       <= '0;
            tx_write_trig <= 1'b0;
            tx_fifo_reset <= 1'b0;
            rx_fifo_reset <= 1'b0;
            ctrl_q        <= '0;
            bus_oe        <= 1'b0;
            bus_dout      <= '0;
            overrun       <= 1'b0;
            nirq          <= 1'b1;
        end else begin
            tx_write_trig <= 1'b0;
            tx_fifo_reset <= 1'b0;
            rx_fifo_reset <= 1'b0;

            if (state == S_IDLE && state_next != S_IDLE) begin
                cyc_addr   <= addr_s;
                rd_empty_q <= rx_empty;
            end

            if (state == S_WRITE) wr_data <= bus_din;

            if (commit) begin
                case (cyc_addr)
                    REG_DATA: begin
                        tx_data       <= wr_data;
                        tx_write_trig <= 1'b1;
                    end
                    REG_CTRL: begin
                        ctrl_q        <= wr_data[2:0];
                        tx_fifo_reset <= wr_data[CTRL_TX_RST];
                        rx_fifo_reset <= wr_data[CTRL_RX_RST];
                    end
                    default: ;
                endcase
            end

            if (state == S_READ && state_next == S_READ) begin
                bus_oe   <= 1'b1;
                bus_dout <= read_mux;
            end else begin
                bus_oe   <= 1'b0;
                bus_dout <= '0;
            end

            // A push into a full FIFO wins over a STATUS-read clear in the same clk.
            if (rx_push && rx_full)                       overrun <= 1'b1;
            else if (read_exit && cyc_addr == REG_STATUS) overrun <= 1'b0;

            nirq <= ~irq_comb;
        end
    end

endmodule
